// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - posted-write store buffer between EX/MEM and the data memory
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [31:0]      Address,
  input  logic [31:0]      WriteData,
  input  logic [1:0]       MemWrite,
  input  logic [1:0]       MemRead,
  input  logic [31:0]      MemReadData,
  output logic [31:0]      MemAddress,
  output logic [31:0]      MemWriteData,
  output logic [1:0]       MemWriteOut,
  output logic [1:0]       MemReadOut,
  output logic [31:0]      ReadData,
  output logic             Stall,
  output logic [CNT_W-1:0] Count
);

  localparam int PTR_W = CNT_W - 1;

  logic [9:0]       ent_idx  [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [1:0]       ent_type [DEPTH];
  logic [PTR_W-1:0] head, tail;

  logic        is_store, is_load, full;
  logic        hit;
  logic [31:0] hit_data;
  logic [1:0]  hit_type;
  logic        load_port, fwd, part, drain, enq;
  logic [31:0] fwd_data;

  // Scan oldest to youngest so the last valid match left standing is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = 32'd0;
    hit_type = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < Count && ent_idx[head + PTR_W'(i)] == Address[11:2]) begin
        hit      = 1'b1;
        hit_data = ent_data[head + PTR_W'(i)];
        hit_type = ent_type[head + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    is_store  = (MemWrite != 2'd0);
    is_load   = !is_store && (MemRead != 2'd0);
    full      = (Count == CNT_W'(DEPTH));
    load_port = is_load && !hit;
    fwd       = is_load && hit && (hit_type == 2'd1);
    part      = is_load && hit && (hit_type != 2'd1);
    drain     = (Count != '0) && !load_port;
    enq       = is_store && !full;
    Stall     = (is_store && full) || part;
  end

  always_comb begin
    case (MemRead)
      2'd2:    fwd_data = {{24{hit_data[7]}}, hit_data[7:0]};
      2'd3:    fwd_data = {{16{hit_data[15]}}, hit_data[15:0]};
      default: fwd_data = hit_data;
    endcase
  end

  always_comb begin
    MemAddress   = 32'd0;
    MemWriteData = 32'd0;
    MemWriteOut  = 2'd0;
    MemReadOut   = 2'd0;
    ReadData     = 32'd0;
    if (load_port) begin
      MemAddress = Address;
      MemReadOut = MemRead;
      ReadData   = MemReadData;
    end else if (drain) begin
      MemAddress   = {20'd0, ent_idx[head], 2'b00};
      MemWriteData = ent_data[head];
      MemWriteOut  = ent_type[head];
    end
    if (fwd) ReadData = fwd_data;
  end

  always_ff @(posedge Clk) begin
    if (enq) begin
      ent_idx[tail]  <= Address[11:2];
      ent_data[tail] <= WriteData;
      ent_type[tail] <= MemWrite;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      head  <= '0;
      tail  <= '0;
      Count <= '0;
    end else begin
      if (enq)   tail <= tail + PTR_W'(1);
      if (drain) head <= head + PTR_W'(1);
      if (enq && !drain)      Count <= Count + CNT_W'(1);
      else if (!enq && drain) Count <= Count - CNT_W'(1);
    end
  end

endmodule

// File: doc/mem_store_buffer.md
# mem_store_buffer

Posted-write store buffer between the EX/MEM pipeline register and the word-addressed data memory of the pipelined datapath. Stores are queued and retired to memory when the port is idle, which keeps SAD inner-loop loads from waiting behind stores. Loads check the buffer in the same cycle and get full-word store data forwarded. When a load hits a pending partial (byte or half) store, the pipeline stalls until that store has drained.

## Interface
- DEPTH, 4: number of buffer entries; must be a power of two ≥ 2.
- CNT_W, 3: width of Count; equals log2(DEPTH)+1.

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Rst  in  1  reset; one clock; reset is asynchronous and active-low.
- Address  in  32  EX/MEM effective address; word index = Address[11:2].
- WriteData  in  32  EX/MEM store data.
- MemWrite  in  2  store request: 0 none, 1 word, 2 byte, 3 half.
- MemRead  in  2  load request: 0 none, 1 word, 2 byte (sign-extended), 3 half (sign-extended).
- MemReadData  in  32  combinational read data returned by the data memory.
- MemAddress  out  32  address driven to the data memory.
- MemWriteData  out  32  write data driven to the data memory.
- MemWriteOut  out  2  write control driven to the data memory (same encoding as MemWrite).
- MemReadOut  out  2  read control driven to the data memory (same encoding as MemRead).
- ReadData  out  32  load result passed to MEM/WB.
- Stall  out  1  request not accepted; upstream holds its inputs and the request is re-presented next cycle.
- Count  out  CNT_W  number of valid entries.

## Operation
- Entry fields: word index [9:0], data [31:0], type [1:0] (1/2/3). The entries form a circular FIFO with head/tail pointers that wrap modulo DEPTH.
- A request is a store if MemWrite≠0. If MemWrite≠0 and MemRead≠0 together, the request is treated as a store only and MemRead is ignored.
- **Store:**
  - If Count<DEPTH, enqueue {Address[11:2], WriteData, MemWrite} at the tail.
  - If Count==DEPTH, assert Stall and do not enqueue. This applies even if a drain occurs in the same cycle.
- **Load, youngest-first search** for entries whose word index equals Address[11:2]:
  - No match: MemReadOut=MemRead, MemAddress=Address, ReadData=MemReadData. The port belongs to the load and there is no drain this cycle.
  - Youngest match has type 1: forward with no memory access (MemReadOut=0).
    - MemRead=1: ReadData=data.
    - MemRead=2: ReadData=sign-extended data[7:0].
    - MemRead=3: ReadData=sign-extended data[15:0].
  - Youngest match has type 2 or 3: assert Stall, set MemReadOut=0 and ReadData=0, and drain. The stall repeats until no partial match remains.
- **Drain:** when Count>0 and the port is not taken by a no-match load, present the head entry:
  - MemWriteOut = type, MemAddress = {20'b0, index, 2'b00}, MemWriteData = data.
  - Pop the head at that rising edge.
- **Idle port:** when neither a load nor a drain owns the port, MemWriteOut=0, MemReadOut=0 and ReadData=0.
- **Simultaneous enqueue and drain:** both happen at the same edge and Count is unchanged.

## Timing
- All outputs are combinational from the current state and current inputs. Count is registered.
- A store accepted at edge n is forwardable to a load presented in cycle n+1. Forwarded loads complete in zero extra cycles.
- A store reaches memory no earlier than the cycle after it is enqueued. Once enqueued, it reaches memory after at most Count cycles in which the port is not taken by a no-match load.
- Partial-hit stall length equals the number of entries up to and including the youngest matching entry, counted from the head.
- **Reset (asynchronous, Rst=0):** Count=0, head=tail=0, all entries invalid. With no request present, the outputs are then Stall=0, MemWriteOut=0, MemReadOut=0 and ReadData=0. Any entries queued when reset asserts mid-operation are discarded and never written.
- Behaviour resumes on the first rising Clk after Rst deasserts.

## Test plan
- **Forwarding and drain:** after reset, store word 0x000000AB to 0x10 then load word 0x10 in the next cycle. Required: ReadData=0x000000AB with MemReadOut=0, Stall=0. The store then drains and memory[4]=0xAB.
- **Full buffer:** issue 5 back-to-back word stores to 0x100–0x110 while loads occupy the port. Required: Count reaches 4, Stall=1 on the 5th store until a drain occurs, and the 5th store is enqueued on the following cycle.
- **Partial-hit stall:** store byte 0x80 to 0x20 then load byte 0x20 immediately. Required: Stall=1 for exactly 1 cycle, the byte is written to memory, then ReadData=0xFFFFFF80 is read from memory.
- **Youngest match wins:** store words 1 then 2 to 0x30, then load 0x30. Required: ReadData=2, and memory ends with 2 after both drain in order.
- **Reset mid-operation:** enqueue 3 stores, then assert Rst low between edges. Required: Count=0 immediately, and no MemWriteOut≠0 occurs after Rst deasserts.
- **Pointer wrap-around:** run 10 alternating word stores and drains to distinct addresses. Required: memory matches the store order and Count returns to 0.
